rank_edge_accum: RTL

- Per-iteration PageRank engine that sits around the rank register file.
- Consumes an edge stream (src, dst). For each edge it reads the contribution of src from a register file read port and accumulates it into an internal per-node accumulator.
- After the last edge, it sweeps every node and writes new_rank = BASE + DAMP*acc into a register file write port.
- The ports connect directly to the register file's readEnable/source/dataOut and writeEnable/dest/dataIn.

---
 rtl/rank_edge_accum.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/rank_edge_accum.sv
// rank_edge_accum: one PageRank iteration around the rank register file.
// Accepts an edge stream (src, dst), reads the contribution of src from the
// register file, accumulates it into a per-node accumulator, then sweeps all
// nodes writing new_rank = BASE + DAMP*acc back into the register file.
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   start                  one-cycle pulse, begins an iteration when idle
//   edge_valid/edge_ready  edge handshake; edge_src/edge_dst/edge_last payload
//   rf_rd_en/rf_rd_addr    register file read request (data returns next cycle)
//   rf_rd_data             register file read data
//   rf_wr_en/rf_wr_addr/rf_wr_data  register file write port
//   busy                   high from start acceptance until done
//   done                   one-cycle pulse when write-back completes
//   addr_err               sticky out-of-range edge flag, cleared on start
module rank_edge_accum #(
  parameter int unsigned WIDTH    = 21,
  parameter int unsigned ADDWIDTH = 5,
  parameter int unsigned N_NODES  = 32,
  parameter int unsigned FRAC     = 20,
  parameter int unsigned DAMP     = 891290,
  parameter int unsigned BASE     = 4915
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                edge_valid,
  output logic                edge_ready,
  input  logic [ADDWIDTH-1:0] edge_src,
  input  logic [ADDWIDTH-1:0] edge_dst,
  input  logic                edge_last,
  output logic                rf_rd_en,
  output logic [ADDWIDTH-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]    rf_rd_data,
  output logic                rf_wr_en,
  output logic [ADDWIDTH-1:0] rf_wr_addr,
  output logic [WIDTH-1:0]    rf_wr_data,
  output logic                busy,
  output logic                done,
  output logic                addr_err
);

  localparam int unsigned PW = WIDTH + FRAC + 1;
  localparam int unsigned SW = WIDTH + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_EDGE  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDWIDTH-1:0] LAST_IDX = ADDWIDTH'(N_NODES - 1);
  localparam logic [ADDWIDTH:0]   NODES_W  = (ADDWIDTH + 1)'(N_NODES);
  localparam logic [WIDTH-1:0]    ACC_MAX  = '1;

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;

  logic                r_edge_ready;
  logic                r_rd_en;
  logic [ADDWIDTH-1:0] r_rd_addr;
  logic                r_wr_en;
  logic [ADDWIDTH-1:0] r_wr_addr;
  logic [WIDTH-1:0]    r_wr_data;
  logic                r_busy;
  logic                r_done;
  logic                r_addr_err;

  logic                w_edge_ready_next;
  logic                w_rd_en_next;
  logic                w_wr_en_next;
  logic                w_busy_next;
  logic                w_done_next;

  logic                r_drain_cnt;
  logic [ADDWIDTH-1:0] r_idx;

  // Destination pipeline: stage 1 while the register file samples, stage 2
  // while its data is on rf_rd_data.
  logic                r_p1_valid;
  logic [ADDWIDTH-1:0] r_p1_dst;
  logic                r_p2_valid;
  logic [ADDWIDTH-1:0] r_p2_dst;

  logic [WIDTH-1:0]    r_acc [N_NODES];

  logic                w_hs;
  logic                w_in_range;
  logic                w_start_ok;
  logic [WIDTH-1:0]    w_add_acc;
  logic [WIDTH-1:0]    w_flush_acc;
  logic [WIDTH:0]      w_add_wide;
  logic [WIDTH-1:0]    w_add_sum;
  logic [PW-1:0]       w_prod;
  logic [SW-1:0]       w_wb_sum;
  logic [WIDTH-1:0]    w_wb_data;

  assign w_hs       = edge_valid & r_edge_ready;
  assign w_in_range = ({1'b0, edge_src} < NODES_W) && ({1'b0, edge_dst} < NODES_W);
  assign w_start_ok = start && (r_state == S_IDLE);

  // Combinational accumulator reads for the add port and the flush port.
  always_comb begin
    w_add_acc   = '0;
    w_flush_acc = '0;
    for (int unsigned n = 0; n < N_NODES; n++) begin
      if (r_p2_dst == ADDWIDTH'(n)) w_add_acc = r_acc[n];
      if (r_idx == ADDWIDTH'(n))    w_flush_acc = r_acc[n];
    end
  end

  // Saturating accumulate.
  assign w_add_wide = {1'b0, w_add_acc} + {1'b0, rf_rd_data};
  assign w_add_sum  = w_add_wide[WIDTH] ? ACC_MAX : w_add_wide[WIDTH-1:0];

  // Write-back value: full-width product, truncated by FRAC, plus BASE, saturated.
  assign w_prod    = PW'(DAMP) * PW'(w_flush_acc);
  assign w_wb_sum  = SW'(BASE) + SW'(w_prod >> FRAC);
  assign w_wb_data = (w_wb_sum > SW'(ACC_MAX)) ? ACC_MAX : w_wb_sum[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and next values of the registered control outputs.
  always_comb begin
    w_state_next = r_state;
    w_rd_en_next = 1'b0;
    w_wr_en_next = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_EDGE;
      end
      S_EDGE: begin
        w_rd_en_next = w_hs & w_in_range;
        if (w_hs && edge_last) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_drain_cnt) w_state_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_wr_en_next = 1'b1;
        if (r_idx == LAST_IDX) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_done_next  = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_edge_ready_next = (w_state_next == S_EDGE);
    // busy stays high through the done pulse and falls the cycle after.
    w_busy_next = (w_state_next != S_IDLE) || (r_state == S_DONE);
  end

  // Registered control outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_edge_ready <= 1'b0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_edge_ready <= w_edge_ready_next;
      r_rd_en      <= w_rd_en_next;
      r_wr_en      <= w_wr_en_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
    end
  end

  // Edge pipeline, read address, error flag and sweep counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p1_valid  <= 1'b0;
      r_p1_dst    <= '0;
      r_p2_valid  <= 1'b0;
      r_p2_dst    <= '0;
      r_rd_addr   <= '0;
      r_addr_err  <= 1'b0;
      r_drain_cnt <= 1'b0;
      r_idx       <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_p2_valid <= r_p1_valid;
      r_p2_dst   <= r_p1_dst;
      r_p1_valid <= w_hs & w_in_range;
      if (w_hs) r_p1_dst <= edge_dst;
      if (w_hs && w_in_range) r_rd_addr <= edge_src;

      if (w_start_ok) begin
        r_addr_err <= 1'b0;
        r_p1_valid <= 1'b0;
        r_p2_valid <= 1'b0;
      end else if (w_hs && !w_in_range) begin
        r_addr_err <= 1'b1;
      end

      if (r_state == S_DRAIN) r_drain_cnt <= ~r_drain_cnt;
      else                    r_drain_cnt <= 1'b0;

      if (r_state == S_FLUSH) begin
        r_idx     <= r_idx + ADDWIDTH'(1);
        r_wr_addr <= r_idx;
        r_wr_data <= w_wb_data;
      end else begin
        r_idx <= '0;
      end
    end
  end

  // Accumulators: cleared on start, added from stage 2, cleared as flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned n = 0; n < N_NODES; n++) r_acc[n] <= '0;
    end else begin
      for (int unsigned n = 0; n < N_NODES; n++) begin
        if (w_start_ok) begin
          r_acc[n] <= '0;
        end else if (r_p2_valid && (r_p2_dst == ADDWIDTH'(n))) begin
          r_acc[n] <= w_add_sum;
        end else if ((r_state == S_FLUSH) && (r_idx == ADDWIDTH'(n))) begin
          r_acc[n] <= '0;
        end
      end
    end
  end

  assign edge_ready = r_edge_ready;
  assign rf_rd_en   = r_rd_en;
  assign rf_rd_addr = r_rd_addr;
  assign rf_wr_en   = r_wr_en;
  assign rf_wr_addr = r_wr_addr;
  assign rf_wr_data = r_wr_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign addr_err   = r_addr_err;

endmodule
